// File: rtl/stage_mem_pkg.sv
// Shared pipeline definitions for the MEM stage: writeback-control bit
// positions, access FSM encodings and the MEM/WB bubble value.
package stage_mem_pkg;

  localparam int WBI_REG_WRITE  = 1;
  localparam int WBI_MEM_TO_REG = 0;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] WBI_BUBBLE = 2'b00;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory req/ack sequencer with a timeout down-counter.
// state    | meaning
// MEM_IDLE | no access outstanding; an aligned access issues a request
// MEM_WAIT | request held stable until ack or timeout abort
module dmem_access_fsm
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        done,
  output logic        abort
);

  mem_state_t state;
  mem_state_t state_next;
  logic [7:0] cnt;
  logic       expired;

  // cnt holds the remaining no-ack cycles; zero marks the final wait cycle
  assign expired = (cnt == 8'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MEM_IDLE;
      cnt        <= 8'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
    end else begin
      state <= state_next;
      if (state == MEM_IDLE && start) begin
        cnt        <= 8'(TIMEOUT - 1);
        dmem_we    <= we_in;
        dmem_addr  <= {addr_in[31:2], 2'b00};
        dmem_wdata <= wdata_in;
      end else if (state == MEM_WAIT && !expired) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MEM_IDLE: if (start) state_next = MEM_WAIT;
      MEM_WAIT: if (ack || expired) state_next = MEM_IDLE;
      default:  state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    case (state)
      MEM_IDLE: stall = start;
      MEM_WAIT: begin
        dmem_req = 1'b1;
        done     = ack;
        abort    = !ack && expired;
        stall    = !ack && !expired;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM stage: branch resolution, data-memory access via dmem_access_fsm,
// and the MEM/WB pipeline register.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] data_b,
  input  logic [4:0]  regaddr,
  input  logic [1:0]  wbi,
  input  logic        M,
  input  logic        is_jump,
  input  logic        branch_eq,
  input  logic        branch_inc,
  input  logic        zero,
  input  logic [31:0] jump_address,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [1:0]  wbi_o,
  output logic [4:0]  regaddr_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_result_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  logic access;
  logic misaligned;
  logic start;
  logic done;
  logic abort;

  assign pc_src        = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
  assign flush         = pc_src;
  assign branch_target = jump_address;

  assign access     = M | wbi[WBI_MEM_TO_REG];
  assign misaligned = alu_result[1:0] != 2'b00;
  assign start      = access & ~misaligned;

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .we_in      (M),
    .addr_in    (alu_result),
    .wdata_in   (data_b),
    .ack        (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .stall      (stall),
    .done       (done),
    .abort      (abort)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      wbi_o        <= WBI_BUBBLE;
      regaddr_o    <= 5'd0;
      mem_data_o   <= 32'd0;
      alu_result_o <= 32'd0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misalign_o <= access & misaligned;
      bus_err_o  <= bus_err_o | abort;
      if (done) begin
        // a store that also claims mem_to_reg is illegal: keep the store, drop writeback
        wbi_o        <= (M & wbi[WBI_MEM_TO_REG]) ? WBI_BUBBLE : wbi;
        regaddr_o    <= regaddr;
        alu_result_o <= alu_result;
        mem_data_o   <= M ? 32'd0 : dmem_rdata;
      end else if (access) begin
        wbi_o        <= WBI_BUBBLE;
        regaddr_o    <= 5'd0;
        alu_result_o <= 32'd0;
        mem_data_o   <= 32'd0;
      end else begin
        wbi_o        <= wbi;
        regaddr_o    <= regaddr;
        alu_result_o <= alu_result;
        mem_data_o   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem: branches, load, store,
// misalignment, timeout abort and reset during an outstanding access.
module tb_stage_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] alu_result, data_b, jump_address, dmem_rdata;
  logic [4:0]  regaddr;
  logic [1:0]  wbi;
  logic        M, is_jump, branch_eq, branch_inc, zero, dmem_ack;
  logic        pc_src, flush, stall, dmem_req, dmem_we, misalign_o, bus_err_o;
  logic [31:0] branch_target, dmem_addr, dmem_wdata, mem_data_o, alu_result_o;
  logic [1:0]  wbi_o;
  logic [4:0]  regaddr_o;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stage_mem #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .alu_result(alu_result), .data_b(data_b),
    .regaddr(regaddr), .wbi(wbi), .M(M), .is_jump(is_jump),
    .branch_eq(branch_eq), .branch_inc(branch_inc), .zero(zero),
    .jump_address(jump_address), .pc_src(pc_src), .branch_target(branch_target),
    .flush(flush), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wbi_o(wbi_o), .regaddr_o(regaddr_o),
    .mem_data_o(mem_data_o), .alu_result_o(alu_result_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    alu_result = 0; data_b = 0; regaddr = 0; wbi = 0; M = 0;
    is_jump = 0; branch_eq = 0; branch_inc = 0; zero = 0;
    jump_address = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    step();
    step();
    check("rst_req", dmem_req, 0);
    check("rst_wbi", wbi_o, 0);
    check("rst_buserr", bus_err_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_memdata", mem_data_o, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;

    // branch resolution
    is_jump = 1; jump_address = 32'h40; #1;
    check("jmp_pcsrc", pc_src, 1);
    check("jmp_flush", flush, 1);
    check("jmp_target", branch_target, 32'h40);
    check("jmp_stall", stall, 0);
    is_jump = 0; branch_eq = 1; zero = 0; #1;
    check("beq_nt_pcsrc", pc_src, 0);
    zero = 1; #1;
    check("beq_t_pcsrc", pc_src, 1);
    branch_eq = 0; branch_inc = 1; zero = 0; #1;
    check("bne_t_pcsrc", pc_src, 1);
    check("bne_t_flush", flush, 1);
    nop(); #1;
    check("nobr_pcsrc", pc_src, 0);

    // load with ack in the third wait cycle
    step();
    alu_result = 32'h100; wbi = 2'b11; regaddr = 5; #1;
    check("ld_issue_stall", stall, 1);
    check("ld_issue_req", dmem_req, 0);
    step();
    check("ld_w1_req", dmem_req, 1);
    check("ld_w1_we", dmem_we, 0);
    check("ld_w1_addr", dmem_addr, 32'h100);
    check("ld_w1_stall", stall, 1);
    check("ld_w1_bubble", wbi_o, 0);
    step();
    check("ld_w2_req", dmem_req, 1);
    check("ld_w2_stall", stall, 1);
    check("ld_w2_bubble", wbi_o, 0);
    step();
    check("ld_w3_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    check("ld_ack_stall", stall, 0);
    step();
    nop(); #1;
    check("ld_wbi", wbi_o, 2'b11);
    check("ld_regaddr", regaddr_o, 5);
    check("ld_memdata", mem_data_o, 32'hDEADBEEF);
    check("ld_alu", alu_result_o, 32'h100);
    check("ld_req_drop", dmem_req, 0);
    check("ld_post_stall", stall, 0);

    // store acked one cycle after the request is seen
    M = 1; alu_result = 32'h20; data_b = 32'h12345678; regaddr = 2; #1;
    check("st_c1_stall", stall, 1);
    step();
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_addr", dmem_addr, 32'h20);
    check("st_wdata", dmem_wdata, 32'h12345678);
    check("st_c2_stall", stall, 1);
    step();
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF; #1;
    check("st_c3_stall", stall, 0);
    step();
    nop(); #1;
    check("st_memdata", mem_data_o, 0);
    check("st_alu", alu_result_o, 32'h20);
    check("st_wbi", wbi_o, 0);
    check("st_req_drop", dmem_req, 0);

    // misaligned load
    alu_result = 32'h102; wbi = 2'b11; regaddr = 7; #1;
    check("mis_stall", stall, 0);
    step();
    nop(); #1;
    check("mis_pulse", misalign_o, 1);
    check("mis_req", dmem_req, 0);
    check("mis_wbi", wbi_o, 0);
    check("mis_regaddr", regaddr_o, 0);
    step();
    check("mis_pulse_end", misalign_o, 0);

    // ack while idle has no effect
    dmem_ack = 1; dmem_rdata = 32'h0BAD0BAD; #1;
    check("idle_ack_stall", stall, 0);
    step();
    dmem_ack = 0; #1;
    check("idle_ack_req", dmem_req, 0);
    check("idle_ack_memdata", mem_data_o, 0);

    // timeout: load never acked
    alu_result = 32'h200; wbi = 2'b11; regaddr = 3; #1;
    check("to_issue_stall", stall, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("to_w%0d_req", k), dmem_req, 1);
      check($sformatf("to_w%0d_stall", k), stall, (k < 16) ? 1 : 0);
      check($sformatf("to_w%0d_buserr", k), bus_err_o, 0);
    end
    step();
    check("to_req_drop", dmem_req, 0);
    check("to_buserr", bus_err_o, 1);
    check("to_bubble", wbi_o, 0);
    M = 0; wbi = 2'b10; regaddr = 9; alu_result = 32'h55; #1;
    check("to_alu_stall", stall, 0);
    step();
    nop(); #1;
    check("to_alu_wbi", wbi_o, 2'b10);
    check("to_alu_regaddr", regaddr_o, 9);
    check("to_alu_result", alu_result_o, 32'h55);
    check("to_buserr_sticky", bus_err_o, 1);

    // reset asserted during wait with a concurrent ack
    alu_result = 32'h300; wbi = 2'b11; regaddr = 4; #1;
    step();
    check("rw_req", dmem_req, 1);
    step();
    reset = 1; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    step();
    reset = 0; nop(); #1;
    check("rw_req", dmem_req, 0);
    check("rw_addr", dmem_addr, 0);
    check("rw_memdata", mem_data_o, 0);
    check("rw_wbi", wbi_o, 0);
    check("rw_regaddr", regaddr_o, 0);
    check("rw_buserr", bus_err_o, 0);
    check("rw_stall", stall, 0);
    step();
    check("rw_idle_req", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
